// File: rtl/pwm_thres_bank.sv
// Double-buffered PWM threshold memory: SPI commands edit the shadow bank, PWM reads the active bank.
// Latency: rdata one cycle after raddr; bank swap on the first frame_sync after COMMIT, then pwm_width copy cycles.
// Backpressure: cmd_ready low while a commit is pending or the copy-back runs; commands offered then are dropped.
module pwm_thres_bank #(
    parameter int pwm_width = 16,
    parameter int num_pwm   = 12,
    localparam int pwm_bits = $clog2(pwm_width)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [pwm_bits-1:0] cmd_addr,
    input  logic [num_pwm-1:0]  cmd_data,
    input  logic                frame_sync,
    input  logic [pwm_bits-1:0] raddr,
    output logic [num_pwm-1:0]  rdata,
    output logic                commit_pending,
    output logic                copy_busy
);

    localparam logic [1:0] OP_WRITE  = 2'd0;
    localparam logic [1:0] OP_SET    = 2'd1;
    localparam logic [1:0] OP_CLEAR  = 2'd2;
    localparam logic [1:0] OP_COMMIT = 2'd3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_COPY    = 2'd2;

    localparam logic [pwm_bits:0]   depth_c = pwm_bits'(pwm_width) == '0 ? {1'b1, {pwm_bits{1'b0}}}
                                                                         : {1'b0, pwm_bits'(pwm_width)};
    localparam logic [pwm_bits-1:0] last_c  = pwm_bits'(pwm_width - 1);

    logic [num_pwm-1:0]  bank [0:1][0:pwm_width-1];
    logic                bank_sel;
    logic                shd_sel;
    logic [1:0]          state;
    logic [pwm_bits-1:0] cnt;
    logic                cmd_in_range;
    logic                rd_in_range;
    logic                cmd_acc;

    assign shd_sel        = ~bank_sel;
    assign cmd_ready      = (state == ST_IDLE);
    assign commit_pending = (state == ST_PENDING);
    assign copy_busy      = (state == ST_COPY);
    assign cmd_acc        = cmd_valid && cmd_ready;
    assign cmd_in_range   = ({1'b0, cmd_addr} < depth_c);
    assign rd_in_range    = ({1'b0, raddr} < depth_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < pwm_width; i++) begin
                    bank[b][i] <= '0;
                end
            end
            bank_sel <= 1'b0;
            state    <= ST_IDLE;
            cnt      <= '0;
            rdata    <= '0;
        end else begin
            // Read uses the pre-edge bank_sel, so the swap edge still returns old-bank data.
            rdata <= rd_in_range ? bank[bank_sel][raddr] : '0;
            case (state)
                ST_IDLE: begin
                    if (cmd_acc) begin
                        if (cmd_op == OP_COMMIT) begin
                            state <= ST_PENDING;
                        end else if (cmd_in_range) begin
                            case (cmd_op)
                                OP_WRITE: bank[shd_sel][cmd_addr] <= cmd_data;
                                OP_SET:   bank[shd_sel][cmd_addr] <= bank[shd_sel][cmd_addr] | cmd_data;
                                OP_CLEAR: bank[shd_sel][cmd_addr] <= bank[shd_sel][cmd_addr] & ~cmd_data;
                                default:  ;
                            endcase
                        end
                    end
                end
                ST_PENDING: begin
                    if (frame_sync) begin
                        bank_sel <= ~bank_sel;
                        state    <= ST_COPY;
                        cnt      <= '0;
                    end
                end
                ST_COPY: begin
                    // Re-sync the new shadow from the freshly committed active bank.
                    bank[shd_sel][cnt] <= bank[bank_sel][cnt];
                    if (cnt == last_c) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_thres_bank.sv
// Randomized and directed bench for pwm_thres_bank against an array-level reference model.
module tb_pwm_thres_bank;

    localparam int W = 16;
    localparam int N = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [3:0]    cmd_addr = 4'd0;
    logic [N-1:0]  cmd_data = '0;
    logic          frame_sync = 1'b0;
    logic [3:0]    raddr = 4'd0;
    logic [N-1:0]  rdata;
    logic          commit_pending;
    logic          copy_busy;

    pwm_thres_bank #(.pwm_width(W), .num_pwm(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_addr       (cmd_addr),
        .cmd_data       (cmd_data),
        .frame_sync     (frame_sync),
        .raddr          (raddr),
        .rdata          (rdata),
        .commit_pending (commit_pending),
        .copy_busy      (copy_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: what the PWM sees (act) and what the next commit will publish (shd).
    logic [N-1:0] act [W];
    logic [N-1:0] shd [W];
    logic [N-1:0] exp_rdata;
    int           phase;      // 0 idle, 1 commit waiting for frame, 2 copy-back
    int           copy_left;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < W; i++) begin
                act[i] = '0;
                shd[i] = '0;
            end
            phase     = 0;
            copy_left = 0;
            exp_rdata = '0;
        end else begin
            exp_rdata = act[raddr];
            if (phase == 0) begin
                if (cmd_valid) begin
                    case (cmd_op)
                        2'd0: shd[cmd_addr] = cmd_data;
                        2'd1: shd[cmd_addr] = shd[cmd_addr] | cmd_data;
                        2'd2: shd[cmd_addr] = shd[cmd_addr] & ~cmd_data;
                        default: phase = 1;
                    endcase
                end
            end else if (phase == 1) begin
                if (frame_sync) begin
                    act       = shd;
                    phase     = 2;
                    copy_left = W;
                end
            end else begin
                copy_left--;
                if (copy_left == 0) phase = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("rdata", 32'(rdata), 32'(exp_rdata));
        chk("cmd_ready", 32'(cmd_ready), 32'(phase == 0));
        chk("commit_pending", 32'(commit_pending), 32'(phase == 1));
        chk("copy_busy", 32'(copy_busy), 32'(phase == 2));
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [N-1:0] d);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
    endtask

    initial begin
        int cnt;

        // Reset and sweep
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_pending", 32'(commit_pending), 32'd0);
        chk("rst_busy", 32'(copy_busy), 32'd0);
        for (int i = 0; i < W; i++) begin
            raddr = 4'(i);
            tick();
            tick();
            chk("rst_sweep", 32'(rdata), 32'd0);
        end

        // Shadow-only write is invisible
        raddr = 4'd3;
        send(2'd0, 4'd3, 12'hA5A);
        tick();
        tick();
        chk("shadow_only", 32'(rdata), 32'h000);

        // Commit with frame_sync 10 cycles later
        send(2'd3, 4'd0, '0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (commit_pending && !cmd_ready) cnt++;
        end
        chk("pending_cycles", 32'(cnt), 32'd10);
        pulse_frame();
        chk("swap_edge_old", 32'(rdata), 32'h000);
        cnt = copy_busy ? 1 : 0;
        tick();
        chk("first_new_read", 32'(rdata), 32'hA5A);
        if (copy_busy) cnt++;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (copy_busy) cnt++;
        end
        chk("copy_cycles", 32'(cnt), 32'd16);
        chk("ready_after_copy", 32'(cmd_ready), 32'd1);

        // Copy-back preserved committed data
        send(2'd1, 4'd3, 12'h005);
        send(2'd2, 4'd3, 12'h00A);
        send(2'd3, 4'd0, '0);
        tick();
        tick();
        pulse_frame();
        for (int i = 0; i < 18; i++) tick();
        chk("set_clear_commit", 32'(rdata), 32'hA55);

        // COMMIT coincident with frame_sync must wait for the next frame
        send(2'd0, 4'd5, 12'h123);
        raddr      = 4'd5;
        frame_sync = 1'b1;
        send(2'd3, 4'd0, '0);
        frame_sync = 1'b0;
        chk("coincident_no_swap", 32'(commit_pending), 32'd1);
        for (int i = 0; i < 19; i++) begin
            cmd_valid = ($urandom_range(0, 1) == 1);
            cmd_op    = 2'($urandom_range(0, 2));
            cmd_addr  = 4'($urandom_range(0, 15));
            cmd_data  = 12'($urandom);
            tick();
        end
        cmd_valid = 1'b0;
        pulse_frame();
        for (int i = 0; i < 17; i++) begin
            cmd_valid = ($urandom_range(0, 1) == 1);
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_addr  = 4'($urandom_range(0, 15));
            cmd_data  = 12'($urandom);
            tick();
        end
        cmd_valid = 1'b0;
        tick();
        chk("late_swap_data", 32'(rdata), 32'h123);

        // Reset in the middle of the copy-back
        send(2'd0, 4'd7, 12'hFFF);
        send(2'd3, 4'd0, '0);
        pulse_frame();
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        chk("midcopy_rst_busy", 32'(copy_busy), 32'd0);
        chk("midcopy_rst_rdata", 32'(rdata), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < W; i++) begin
            raddr = 4'(i);
            tick();
        end
        tick();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 599) == 0);
            cmd_valid  = ($urandom_range(0, 9) < 3);
            cmd_op     = 2'($urandom_range(0, 3));
            cmd_addr   = 4'($urandom_range(0, 15));
            cmd_data   = 12'($urandom);
            frame_sync = ($urandom_range(0, 19) == 0);
            raddr      = 4'($urandom_range(0, 15));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
